// File: rtl/ifid_queue_pkg.sv
// Shared fetch/decode constants and the buffered fetch packet type.
package ifid_queue_pkg;

  // Canonical RISC-V NOP: addi x0, x0, 0
  localparam logic [31:0] NOP_ENC  = 32'h0000_0013;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;

  // One buffered fetch packet: 64 bits of {pc, instr}
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/ifid_queue.sv
// Two-entry IF/ID skid queue between fetch and decode.
// Outputs are driven from registered state only, so o_rdy has no
// combinational dependence on i_vld or i_dec_rdy.
module ifid_queue
  import ifid_queue_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic        i_vld,
  output logic        o_rdy,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_vld,
  input  logic        i_dec_rdy,
  input  logic        i_flush,
  output logic [1:0]  o_count
);

  localparam logic [1:0] CNT_FULL = 2'(DEPTH);

  fetch_pkt_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  // Flush wins over both push and pop.
  assign push = i_vld && o_rdy && !i_flush;
  assign pop  = o_vld && i_dec_rdy && !i_flush;

  // Occupancy and pointer update; reset and flush both empty the queue.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (i_flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Packet storage written at the write pointer on an accepted push.
  // NOTE: the data registers carry no reset; stale contents are never
  // visible because every output is masked by o_vld.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: i_pc, instr: i_instr};
  end

  assign o_count = count;
  assign o_vld   = (count != 2'd0);
  assign o_rdy   = (count != CNT_FULL);
  assign o_pc    = o_vld ? mem[rd_ptr].pc    : PC_RESET;
  assign o_instr = o_vld ? mem[rd_ptr].instr : NOP_INSTR;

endmodule

// File: tb/tb_ifid_queue.sv
// Directed bench for ifid_queue. The driver pushes each packet it knows
// will be accepted into an expected queue; a monitor pops and compares
// whenever decode actually consumes the head.
module tb_ifid_queue;
  import ifid_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_pc;
  logic [31:0] i_instr;
  logic        i_vld;
  logic        o_rdy;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        o_vld;
  logic        i_dec_rdy;
  logic        i_flush;
  logic [1:0]  o_count;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_pkt_t exp_q [$];

  ifid_queue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_pc      (i_pc),
    .i_instr   (i_instr),
    .i_vld     (i_vld),
    .o_rdy     (o_rdy),
    .o_pc      (o_pc),
    .o_instr   (o_instr),
    .o_vld     (o_vld),
    .i_dec_rdy (i_dec_rdy),
    .i_flush   (i_flush),
    .o_count   (o_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic status(input string name, input logic vld, input logic rdy,
                        input logic [1:0] cnt);
    check({name, ".vld"},   64'(o_vld),   64'(vld));
    check({name, ".rdy"},   64'(o_rdy),   64'(rdy));
    check({name, ".count"}, 64'(o_count), 64'(cnt));
  endtask

  task automatic drive(input logic vld, input logic [31:0] pc, input logic [31:0] instr);
    i_vld   = vld;
    i_pc    = pc;
    i_instr = instr;
  endtask

  // Monitor: mid-cycle, a consumed head must match the oldest expected packet.
  always @(negedge clk) begin
    if (rst_n && o_vld && i_dec_rdy && !i_flush) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got pc=%h instr=%h, expected no packet", o_pc, o_instr);
      end else begin
        fetch_pkt_t e;
        e = exp_q.pop_front();
        check("pop_pkt", {o_pc, o_instr}, {e.pc, e.instr});
      end
    end
  end

  initial begin
    rst_n = 1'b0; i_flush = 1'b0; i_dec_rdy = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset then idle
    status("idle", 1'b0, 1'b1, 2'd0);
    check("idle.instr", 64'(o_instr), 64'h13);
    check("idle.pc",    64'(o_pc),    64'h0);

    // Single packet, decode always ready: visible after one edge, gone after next
    i_dec_rdy = 1'b1;
    drive(1'b1, 32'h0, 32'h0050_0093);
    exp_q.push_back('{pc: 32'h0, instr: 32'h0050_0093});
    tick();
    drive(1'b0, 32'h0, 32'h0);
    status("single.after_push", 1'b1, 1'b1, 2'd1);
    check("single.instr", 64'(o_instr), 64'h0050_0093);
    tick();
    status("single.after_pop", 1'b0, 1'b1, 2'd0);

    // Fill with decode stalled; third packet must be dropped
    i_dec_rdy = 1'b0;
    drive(1'b1, 32'h0, 32'h0000_0111);
    exp_q.push_back('{pc: 32'h0, instr: 32'h0000_0111});
    tick();
    drive(1'b1, 32'h4, 32'h0000_0222);
    exp_q.push_back('{pc: 32'h4, instr: 32'h0000_0222});
    tick();
    status("full", 1'b1, 1'b0, 2'd2);
    drive(1'b1, 32'h8, 32'h0000_0333);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    status("full.drop", 1'b1, 1'b0, 2'd2);
    check("full.head_stable", 64'(o_pc), 64'h0);
    i_dec_rdy = 1'b1;
    tick();
    status("drain1", 1'b1, 1'b1, 2'd1);
    check("drain1.head", 64'(o_pc), 64'h4);

    // Count 1 with head 0x4: simultaneous push 0x8 and pop
    drive(1'b1, 32'h8, 32'h0000_0444);
    exp_q.push_back('{pc: 32'h8, instr: 32'h0000_0444});
    tick();
    drive(1'b0, 32'h0, 32'h0);
    status("pushpop", 1'b1, 1'b1, 2'd1);
    check("pushpop.head", 64'(o_pc), 64'h8);
    tick();
    status("pushpop.drain", 1'b0, 1'b1, 2'd0);

    // Full, pop plus ignored push in the same cycle frees exactly one slot
    i_dec_rdy = 1'b0;
    drive(1'b1, 32'h30, 32'h0000_0555);
    exp_q.push_back('{pc: 32'h30, instr: 32'h0000_0555});
    tick();
    drive(1'b1, 32'h34, 32'h0000_0666);
    exp_q.push_back('{pc: 32'h34, instr: 32'h0000_0666});
    tick();
    i_dec_rdy = 1'b1;
    drive(1'b1, 32'h38, 32'h0000_0777);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    status("full_pop", 1'b1, 1'b1, 2'd1);
    check("full_pop.head", 64'(o_pc), 64'h34);
    tick();
    status("full_pop.drain", 1'b0, 1'b1, 2'd0);

    // Flush at count 2 with a same-cycle incoming packet
    i_dec_rdy = 1'b0;
    drive(1'b1, 32'h20, 32'h0000_0888);
    tick();
    drive(1'b1, 32'h24, 32'h0000_0999);
    tick();
    status("pre_flush", 1'b1, 1'b0, 2'd2);
    i_flush = 1'b1;
    i_dec_rdy = 1'b1;
    drive(1'b1, 32'h10, 32'h0000_0aaa);
    tick();
    i_flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    status("flush", 1'b0, 1'b1, 2'd0);
    check("flush.instr", 64'(o_instr), 64'h13);
    check("flush.pc",    64'(o_pc),    64'h0);
    tick(); tick();
    check("flush.no_emit", 64'(o_vld), 64'h0);

    // Reset mid-operation at count 2
    i_dec_rdy = 1'b0;
    drive(1'b1, 32'h40, 32'h0000_0bbb);
    tick();
    drive(1'b1, 32'h44, 32'h0000_0ccc);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    status("pre_rst", 1'b1, 1'b0, 2'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    status("mid_rst", 1'b0, 1'b1, 2'd0);
    i_dec_rdy = 1'b1;
    tick(); tick(); tick();
    check("mid_rst.no_emit", 64'(o_vld), 64'h0);

    check("exp_q.empty", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
